// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main-control FSM: Moore decode of state, ready-handshaked memory, bus-timeout watchdog.
// Define MULTICYCLE_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_control #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic             bus_error
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state_q;
  state_t     nxt;
  logic       live_q;
  logic [7:0] wait_cnt_q;
  logic       bus_err_q;
  logic       mem_wait;
  logic       timeout;

  // funct and zero are consumed by the datapath (ALU control, branch gating), not by this FSM.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  always_comb begin
    nxt      = state_q;
    mem_wait = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_ready;
    timeout  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDIEX;
          default:      nxt = S_HALT;
        endcase
      end
      S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_HALT;
    endcase
    if (mem_wait && wait_cnt_q == WAIT_LIM) begin
      nxt     = S_HALT;
      timeout = 1'b1;
    end
  end

  // live_q holds the FSM for the first edge after reset release so FETCH starts cleanly on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q     <= 1'b0;
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else if (!live_q) begin
      live_q <= 1'b1;
    end else begin
      state_q    <= nxt;
      wait_cnt_q <= (mem_wait && !timeout) ? wait_cnt_q + 1'b1 : '0;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    if (live_q) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign bus_error = bus_err_q;

`ifdef MULTICYCLE_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (live_q) begin
      if (state_q != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
